mem_port_arbiter: RTL

- Shares the single main-memory port between two cache controllers, e.g. I-cache and D-cache instances of the 2-way set-associative cache.
- Grants one requester at a time and sequences a block burst of BURST_LEN beats (read fill or write-back) against the memory ready handshake.
- Sits between the cache miss/write-back logic and the memory model/controller.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_rr.sv | 17 +
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to rr_ptr.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       gnt_idx
);

    // Tie-break on rr_ptr, otherwise take whichever port is asking.
    always_comb begin
        gnt_idx = 1'b0;
        if (req == 2'b11)
            gnt_idx = rr_ptr;
        else if (req[1])
            gnt_idx = 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two cache controllers, running one
// BURST_LEN-beat block read or write-back at a time.
// Optional watchdog abort: define MEM_PORT_ARBITER_TIMEOUT_EN (adds err).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 64
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_rd,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_gnt,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_rvalid,
    output logic              req0_wnext,
    output logic              req0_done,
    input  logic              req1_rd,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_gnt,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_rvalid,
    output logic              req1_wnext,
    output logic              req1_done,
    output logic [ADDR_W-1:0] addr_mem,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [DATA_W-1:0] wdata_mem,
    input  logic [DATA_W-1:0] rdata_mem,
    input  logic              ready_mem,
    output logic              busy
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    localparam int                BW        = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(BURST_LEN - 1);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);

    state_t            state;
    op_t               op;
    logic              owner;
    logic              rr_ptr;
    logic [BW-1:0]     beat;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic              rd_q;
    logic              wr_q;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;

    logic [1:0]        req_any;
    logic              win;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic              timeout_hit;
    logic              burst_end;
    logic              is_rd;

    assign req_any  = {req1_rd | req1_wr, req0_rd | req0_wr};
    // A write on the winning port takes priority; its read stays pending.
    assign win_wr   = win ? req1_wr : req0_wr;
    assign win_addr = win ? req1_addr : req0_addr;

    rr_arbiter_2 u_arb (
        .req     (req_any),
        .rr_ptr  (rr_ptr),
        .gnt_idx (win)
    );

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT);
    logic [WDW-1:0] wd_cnt;
    logic           err_q;

    assign timeout_hit = (state == BURST) && !ready_mem && (wd_cnt == WDW'(TIMEOUT - 1));
    assign err         = err_q;

    // Watchdog: cycles in BURST since entry or the last ready; err rides with done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state != BURST || ready_mem)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WDW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign burst_end = (state == BURST) && ((ready_mem && beat == LAST_BEAT) || timeout_hit);

    // Main sequencer: grant, step beats on ready, pulse done, rotate priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op     <= OP_RD;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
            beat   <= '0;
            gnt_q  <= '0;
            done_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            busy_q <= 1'b0;
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_any) begin
                        state  <= BURST;
                        owner  <= win;
                        op     <= win_wr ? OP_WR : OP_RD;
                        beat   <= '0;
                        addr_q <= win_addr & BLK_MASK;
                        gnt_q  <= win ? 2'b10 : 2'b01;
                        busy_q <= 1'b1;
                        rd_q   <= ~win_wr;
                        wr_q   <= win_wr;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        state  <= DONE;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        rd_q   <= 1'b0;
                        wr_q   <= 1'b0;
                        beat   <= '0;
                        addr_q <= '0;
                        done_q <= owner ? 2'b10 : 2'b01;
                    end else if (ready_mem) begin
                        // Never the last beat here, so the block boundary is not crossed.
                        beat   <= beat + BW'(1);
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                DONE: begin
                    done_q <= '0;
                    rr_ptr <= ~owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign is_rd       = (op == OP_RD);
    assign addr_mem    = addr_q;
    assign rd_mem      = rd_q;
    assign wr_mem      = wr_q;
    assign busy        = busy_q;
    assign wdata_mem   = wr_q ? (owner ? req1_wdata : req0_wdata) : '0;

    assign req0_gnt    = gnt_q[0];
    assign req0_done   = done_q[0];
    assign req0_rvalid = gnt_q[0] & is_rd & ready_mem;
    assign req0_wnext  = gnt_q[0] & ~is_rd & ready_mem;
    assign req0_rdata  = (gnt_q[0] && is_rd) ? rdata_mem : '0;

    assign req1_gnt    = gnt_q[1];
    assign req1_done   = done_q[1];
    assign req1_rvalid = gnt_q[1] & is_rd & ready_mem;
    assign req1_wnext  = gnt_q[1] & ~is_rd & ready_mem;
    assign req1_rdata  = (gnt_q[1] && is_rd) ? rdata_mem : '0;

endmodule
